// File: rtl/game_pkg.sv
// Shared types and constants for the whack-a-box game controller.
package game_pkg;

    typedef enum logic [2:0] {
        LOBBY,
        PICK,
        SHOW,
        HIT,
        GAMEOVER
    } state_t;

    localparam logic [2:0]  MIF_LOBBY    = 3'd0;
    localparam logic [2:0]  MIF_GAMEOVER = 3'd7;
    localparam logic [2:0]  BOX_NONE     = 3'd0;
    localparam logic [10:0] SCORE_MAX    = 11'd2047;

    // Score increment that sticks at SCORE_MAX instead of wrapping.
    function automatic logic [10:0] score_inc(input logic [10:0] value);
        return (value == SCORE_MAX) ? value : value + 11'd1;
    endfunction

endpackage

// File: rtl/second_tick.sv
// Divides the clock down to a one-cycle pulse every CLK_HZ enabled cycles.
module second_tick #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [25:0] COUNT_LAST = 26'(CLK_HZ - 1);

    logic [25:0] count;

    assign tick = enable && (count == COUNT_LAST);

    // Divider counter: synchronous clear wins, otherwise counts while enabled.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == COUNT_LAST) ? '0 : count + 26'd1;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Game sequencer: lobby, target draws, hit scoring, countdown and game over.
module game_controller
    import game_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int GAME_SECONDS    = 60,
    parameter int TARGET_CYCLES   = 75_000_000,
    parameter int HIT_HOLD_CYCLES = 12_500_000,
    parameter int NUM_BOXES       = 6
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  box_address,
    input  logic [2:0]  lfsr_value,
    output logic        lfsr_advance,
    output logic [2:0]  mif_control_signal,
    output logic [10:0] score,
    output logic [5:0]  game_timer,
    output logic        play_sound,
    output logic        lobby_sound,
    output logic        game_over
);

    localparam logic [26:0] TARGET_LAST = 27'(TARGET_CYCLES - 1);
    localparam logic [26:0] HOLD_LAST   = 27'(HIT_HOLD_CYCLES - 1);
    localparam logic [5:0]  TIMER_LOAD  = 6'(GAME_SECONDS);
    localparam logic [2:0]  BOX_MAX     = 3'(NUM_BOXES);

    state_t      state, state_n;
    logic        pick_phase, pick_phase_n;   // 0: advance LFSR, 1: sample it
    logic [2:0]  target, target_n;
    logic [2:0]  prev_target, prev_target_n;
    logic [26:0] on_cnt, on_cnt_n;
    logic [26:0] hold_cnt, hold_cnt_n;
    logic [2:0]  box_meta, box_sync;
    logic [2:0]  mif_n;
    logic [10:0] score_n;
    logic [5:0]  timer_n;
    logic        play_sound_n, lfsr_advance_n;
    logic        tick, tick_en, tick_clear, draw_ok;

    assign tick_en    = (state == PICK) || (state == SHOW) || (state == HIT);
    assign tick_clear = (state == LOBBY) && start;
    assign draw_ok    = (lfsr_value != BOX_NONE) && (lfsr_value <= BOX_MAX)
                        && (lfsr_value != prev_target);

    second_tick #(.CLK_HZ(CLK_HZ)) u_second_tick (
        .clk    (CLOCK_50),
        .rst_n  (resetn),
        .clear  (tick_clear),
        .enable (tick_en),
        .tick   (tick)
    );

    // Two-flop synchronizer for the asynchronous strike address.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            box_meta <= BOX_NONE;
            box_sync <= BOX_NONE;
        end else begin
            box_meta <= box_address;
            box_sync <= box_meta;
        end
    end

    // Next-state and next-output logic; countdown expiry overrides everything.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_n        = state;
        pick_phase_n   = pick_phase;
        target_n       = target;
        prev_target_n  = prev_target;
        on_cnt_n       = on_cnt;
        hold_cnt_n     = hold_cnt;
        mif_n          = mif_control_signal;
        score_n        = score;
        timer_n        = game_timer;
        play_sound_n   = 1'b0;
        lfsr_advance_n = 1'b0;

        case (state)
            LOBBY: begin
                if (start) begin
                    state_n        = PICK;
                    pick_phase_n   = 1'b0;
                    lfsr_advance_n = 1'b1;
                    score_n        = '0;
                    timer_n        = TIMER_LOAD;
                    prev_target_n  = BOX_NONE;
                end
            end
            PICK: begin
                if (!pick_phase) begin
                    pick_phase_n = 1'b1;
                end else if (draw_ok) begin
                    state_n       = SHOW;
                    target_n      = lfsr_value;
                    prev_target_n = lfsr_value;
                    on_cnt_n      = '0;
                    mif_n         = lfsr_value;
                end else begin
                    pick_phase_n   = 1'b0;
                    lfsr_advance_n = 1'b1;
                end
            end
            SHOW: begin
                if (box_sync == target) begin
                    state_n      = HIT;
                    score_n      = score_inc(score);
                    play_sound_n = 1'b1;
                    hold_cnt_n   = '0;
                end else if (on_cnt == TARGET_LAST) begin
                    state_n        = PICK;
                    pick_phase_n   = 1'b0;
                    lfsr_advance_n = 1'b1;
                end else begin
                    on_cnt_n = on_cnt + 27'd1;
                end
            end
            HIT: begin
                if ((box_sync == BOX_NONE) && (hold_cnt >= HOLD_LAST)) begin
                    state_n        = PICK;
                    pick_phase_n   = 1'b0;
                    lfsr_advance_n = 1'b1;
                end else if (hold_cnt < HOLD_LAST) begin
                    hold_cnt_n = hold_cnt + 27'd1;
                end
            end
            GAMEOVER: begin
                if (start) begin
                    state_n = LOBBY;
                    mif_n   = MIF_LOBBY;
                end
            end
            default: begin
                state_n = LOBBY;
                mif_n   = MIF_LOBBY;
            end
        endcase

        if (tick_en && tick) begin
            if (game_timer == 6'd1) begin
                state_n        = GAMEOVER;
                timer_n        = '0;
                score_n        = score;
                play_sound_n   = 1'b0;
                lfsr_advance_n = 1'b0;
                mif_n          = MIF_GAMEOVER;
            end else if (game_timer != 6'd0) begin
                timer_n = game_timer - 6'd1;
            end
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state              <= LOBBY;
            pick_phase         <= 1'b0;
            target             <= BOX_NONE;
            prev_target        <= BOX_NONE;
            on_cnt             <= '0;
            hold_cnt           <= '0;
            mif_control_signal <= MIF_LOBBY;
            score              <= '0;
            game_timer         <= TIMER_LOAD;
            play_sound         <= 1'b0;
            lfsr_advance       <= 1'b0;
            lobby_sound        <= 1'b1;
            game_over          <= 1'b0;
        end else begin
            state              <= state_n;
            pick_phase         <= pick_phase_n;
            target             <= target_n;
            prev_target        <= prev_target_n;
            on_cnt             <= on_cnt_n;
            hold_cnt           <= hold_cnt_n;
            mif_control_signal <= mif_n;
            score              <= score_n;
            game_timer         <= timer_n;
            play_sound         <= play_sound_n;
            lfsr_advance       <= lfsr_advance_n;
            lobby_sound        <= (state_n == LOBBY);
            game_over          <= (state_n == GAMEOVER);
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller against a transaction-level model.
module tb_game_controller;

    localparam int CLK_HZ = 100;
    localparam int GS     = 3;
    localparam int TGT    = 50;
    localparam int HOLD   = 10;

    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  box_address = 3'd0;
    logic [2:0]  lfsr_value = 3'd0;
    logic        lfsr_advance;
    logic [2:0]  mif_control_signal;
    logic [10:0] score;
    logic [5:0]  game_timer;
    logic        play_sound;
    logic        lobby_sound;
    logic        game_over;

    game_controller #(
        .CLK_HZ(CLK_HZ), .GAME_SECONDS(GS), .TARGET_CYCLES(TGT),
        .HIT_HOLD_CYCLES(HOLD), .NUM_BOXES(6)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
        .box_address(box_address), .lfsr_value(lfsr_value),
        .lfsr_advance(lfsr_advance), .mif_control_signal(mif_control_signal),
        .score(score), .game_timer(game_timer), .play_sound(play_sound),
        .lobby_sound(lobby_sound), .game_over(game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int adv_count = 0;
    int snd_count = 0;
    logic [2:0] lfsr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge CLOCK_50) cyc++;

    // LFSR stand-in: steps to the next queued value whenever the DUT asks;
    // also counts advance requests and sound pulses.
    always @(negedge CLOCK_50) begin
        if (lfsr_advance) begin
            adv_count++;
            if (lfsr_q.size() > 0) lfsr_value = lfsr_q.pop_front();
            else lfsr_value = 3'($urandom_range(0, 7));
        end
        if (play_sound) snd_count++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic do_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    function automatic int elapsed();
        return cyc - start_cyc;
    endfunction

    // Model: first queued value that is a valid box and differs from prev.
    function automatic logic [2:0] model_pick(input logic [2:0] prev, output int draws);
        draws = 0;
        foreach (lfsr_q[i]) begin
            if (lfsr_q[i] >= 3'd1 && lfsr_q[i] <= 3'd6 && lfsr_q[i] != prev) begin
                draws = i + 1;
                return lfsr_q[i];
            end
        end
        return 3'd0;
    endfunction

    function automatic logic [2:0] rand_box(input logic [2:0] avoid);
        logic [2:0] v;
        v = 3'($urandom_range(1, 6));
        if (v == avoid) v = (v == 3'd6) ? 3'd1 : v + 3'd1;
        return v;
    endfunction

    task automatic wait_mif(input logic [2:0] v, input int budget, input string tag);
        for (int i = 0; i < budget && mif_control_signal != v; i++) step();
        check(tag, mif_control_signal, v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mif"}, mif_control_signal, 0);
        check({tag, "_lobby"}, lobby_sound, 1);
        check({tag, "_score"}, score, 0);
        check({tag, "_timer"}, game_timer, GS);
        check({tag, "_sound"}, play_sound, 0);
        check({tag, "_adv"}, lfsr_advance, 0);
        check({tag, "_over"}, game_over, 0);
    endtask

    initial begin
        int m_score, nd, a0, s0, c0, gap, hit_c;
        logic [2:0] m_prev, exp_t;
        logic [2:0] show_list[6];

        // Reset
        repeat (3) step();
        check_reset_values("reset");
        resetn = 1'b1;
        step();

        // Round 1: first draw
        lfsr_q.push_back(3'd4);
        exp_t = model_pick(3'd0, nd);
        a0 = adv_count;
        do_start();
        m_score = 0;
        check("pick_mif_held", mif_control_signal, 0);
        check("timer_load", game_timer, GS);
        check("lobby_off", lobby_sound, 0);
        wait_mif(exp_t, 10, "first_target");
        check("first_draws", adv_count - a0, nd);
        m_prev = exp_t;

        // Held strike scores once; queue the rejection sequence before release
        s0 = snd_count;
        box_address = exp_t;
        repeat (30) step();
        m_score++;
        check("hit_score", score, m_score);
        check("hit_one_pulse", snd_count - s0, 1);
        lfsr_q.push_back(3'd0);
        lfsr_q.push_back(3'd7);
        lfsr_q.push_back(3'd4);
        lfsr_q.push_back(3'd2);
        exp_t = model_pick(m_prev, nd);
        a0 = adv_count;
        box_address = 3'd0;
        wait_mif(exp_t, 60, "reject_target");
        check("reject_draws", adv_count - a0, nd);
        m_prev = exp_t;

        // Non-target strike is ignored
        s0 = snd_count;
        box_address = 3'd5;
        repeat (6) step();
        box_address = 3'd0;
        check("wrong_box_score", score, m_score);
        check("wrong_box_sound", snd_count - s0, 0);

        // Short tap: HIT must still last the hold time before the next draw
        for (int i = 0; i < 3; i++) lfsr_q.push_back(3'($urandom_range(0, 7)));
        lfsr_q.push_back(rand_box(m_prev));
        exp_t = model_pick(m_prev, nd);
        a0 = adv_count;
        s0 = snd_count;
        hit_c = -1;
        gap = -1;
        box_address = m_prev;
        step();
        step();
        box_address = 3'd0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (snd_count != s0 && hit_c < 0) hit_c = cyc;
            if (adv_count != a0) begin
                gap = (hit_c < 0) ? -1 : cyc - hit_c;
                break;
            end
        end
        check("hold_gap_ok", (gap >= HOLD && gap <= HOLD + 1), 1);
        m_score++;
        check("tap_score", score, m_score);
        check("tap_pulse", snd_count - s0, 1);
        wait_mif(exp_t, 60, "rand_target");
        check("rand_draws", adv_count - a0, nd);
        m_prev = exp_t;

        // Miss: target stays lit TGT cycles, then a new draw
        c0 = cyc;
        a0 = adv_count;
        for (int i = 0; i < 70 && adv_count == a0; i++) step();
        check("miss_len", cyc - c0, TGT);
        check("miss_score", score, m_score);
        check("timer_mid", game_timer, GS - elapsed() / CLK_HZ);

        // Round 1 expiry
        for (int i = 0; i < 400 && elapsed() < GS * CLK_HZ; i++) step();
        check("r1_over_mif", mif_control_signal, 7);
        check("r1_over_flag", game_over, 1);
        check("r1_over_timer", game_timer, 0);
        check("r1_over_score", score, m_score);
        do_start();
        check("r1_lobby_mif", mif_control_signal, 0);
        check("r1_lobby_sound", lobby_sound, 1);
        check("r1_lobby_over", game_over, 0);

        // Round 2: every draw accepted first time, so SHOW windows are fixed;
        // a strike lands on the expiry cycle and must not count.
        lfsr_q.delete();
        m_prev = 3'd0;
        for (int i = 0; i < 6; i++) begin
            show_list[i] = rand_box(m_prev);
            lfsr_q.push_back(show_list[i]);
            m_prev = show_list[i];
        end
        do_start();
        m_score = 0;
        s0 = snd_count;
        check("r2_score_clear", score, 0);
        for (int i = 0; i < 400 && elapsed() < GS * CLK_HZ; i++) begin
            step();
            for (int j = 0; j < 6; j++)
                if (elapsed() == 2 + (TGT + 2) * j)
                    check($sformatf("r2_show%0d", j), mif_control_signal, show_list[j]);
            if (elapsed() == 297) box_address = show_list[5];
            if (elapsed() == 99) check("r2_timer_99", game_timer, 3);
            if (elapsed() == 100) check("r2_timer_100", game_timer, 2);
            if (elapsed() == 299) begin
                check("r2_timer_299", game_timer, 1);
                check("r2_not_over", game_over, 0);
            end
        end
        check("r2_over_mif", mif_control_signal, 7);
        check("r2_over_flag", game_over, 1);
        check("r2_over_timer", game_timer, 0);
        check("r2_expiry_score", score, m_score);
        check("r2_expiry_sound", snd_count - s0, 0);
        box_address = 3'd0;
        do_start();
        check("r2_lobby_mif", mif_control_signal, 0);

        // Round 3: saturation, then reset in the middle of SHOW
        lfsr_q.delete();
        lfsr_q.push_back(3'd3);
        do_start();
        wait_mif(3'd3, 10, "r3_target");
        force dut.score = 11'd2047;
        step();
        release dut.score;
        step();
        s0 = snd_count;
        lfsr_q.push_back(3'd5);
        box_address = 3'd3;
        repeat (6) step();
        box_address = 3'd0;
        check("sat_score", score, 2047);
        check("sat_pulse", snd_count - s0, 1);
        wait_mif(3'd5, 40, "r3_next_target");
        box_address = 3'd5;
        step();
        resetn = 1'b0;
        step();
        check_reset_values("midreset");
        s0 = snd_count;
        resetn = 1'b1;
        repeat (5) step();
        check("midreset_no_sound", snd_count - s0, 0);
        check("midreset_lobby", lobby_sound, 1);
        box_address = 3'd0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
